// File: rtl/booth_disp_pkg.sv
// Shared constants, FSM state type and the seven-segment encoder for the
// Booth product display path.
package booth_disp_pkg;

  localparam int N_DIGITS = 8;
  localparam int N_BCD    = 5;
  localparam int BIN_W    = 16;
  localparam int BCD_W    = 4 * N_BCD;

  // Segment codes, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // BCD nibble to segment pattern; non-decimal nibbles render blank.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/booth_display_scan_bin2bcd_seq.sv
// Sequential double-dabble: converts a 16-bit magnitude to five BCD digits,
// one shift per cycle over 16 cycles.
//
// Handshake: start_i is honoured only while busy_o=0 (state IDLE). busy_o
// stays high from the edge that accepts start_i until the edge performing
// the 16th shift. During that final cycle last_o=1 and bcd_o carries the
// finished result, so a consumer can capture it on the same edge; done_o
// is the registered one-cycle pulse that follows that edge.
module bin2bcd_seq
  import booth_disp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [BIN_W-1:0]   bin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               last_o,
  output logic [BCD_W-1:0]   bcd_o,
  output state_t             state_o
);

  localparam logic [3:0] ITER_LAST = 4'd15;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_sh;
  logic [BIN_W-1:0]   bin_sh;
  logic               last;

  // Add-3 correction on every nibble >= 5, then shift BCD:binary left by one
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < N_BCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_sh = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    bin_sh = {bin_q[BIN_W-2:0], 1'b0};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          cnt_d   = 4'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        bin_d = bin_sh;
        bcd_d = bcd_sh;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == ITER_LAST) begin
          last    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      bin_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy_o  = (state_q == CONV);
  assign done_o  = done_q;
  assign last_o  = last;
  assign bcd_o   = bcd_sh;
  assign state_o = state_q;

endmodule

// File: rtl/booth_display_scan.sv
// Captures a signed/unsigned 16-bit product, converts it to decimal and
// scans it onto an 8-digit active-low multiplexed seven-segment display.
//
// Handshake: load is accepted on a rising edge only while busy=0; loads
// seen while busy=1 are dropped. done pulses for one cycle once the new
// value is in the display registers; the display keeps the previous value
// until then.
module booth_display_scan
  import booth_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        signed_mode,
  output logic        busy,
  output logic        done,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        dbg_state
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic               accept;
  logic               sign_in;
  logic [BIN_W-1:0]   mag_in;

  logic               conv_busy;
  logic               conv_done;
  logic               conv_last;
  logic [BCD_W-1:0]   conv_bcd;
  state_t             conv_state;

  logic               sign_pend_q, sign_pend_d;
  logic [BCD_W-1:0]   disp_bcd_q, disp_bcd_d;
  logic               disp_sign_q, disp_sign_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic [4:1]         lz;

  // Sign/magnitude split of the incoming product
  always_comb begin
    accept  = load & ~conv_busy;
    sign_in = signed_mode & value[15];
    mag_in  = sign_in ? (~value + 16'd1) : value;
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .bin_i   (mag_in),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .last_o  (conv_last),
    .bcd_o   (conv_bcd),
    .state_o (conv_state)
  );

  // Pending sign and double-buffered display registers
  always_comb begin
    sign_pend_d = accept ? sign_in : sign_pend_q;
    disp_bcd_d  = conv_last ? conv_bcd : disp_bcd_q;
    disp_sign_d = conv_last ? sign_pend_q : disp_sign_q;
  end

  // Refresh counter and digit index; load never disturbs the scan
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    idx_d = idx_q;
    if (cnt_q == DIV_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Leading-zero blanking: digit k is blank while digits k..4 are all zero
  always_comb begin
    lz[4] = (disp_bcd_q[19:16] == 4'd0);
    lz[3] = lz[4] & (disp_bcd_q[15:12] == 4'd0);
    lz[2] = lz[3] & (disp_bcd_q[11:8] == 4'd0);
    lz[1] = lz[2] & (disp_bcd_q[7:4] == 4'd0);
  end

  // Scan mux: enable and segment pattern for the current digit index
  always_comb begin
    an_d  = ~(8'b1 << idx_q);
    seg_d = SEG_BLANK;
    case (idx_q)
      3'd0:    seg_d = seg_of(disp_bcd_q[3:0]);
      3'd1:    seg_d = lz[1] ? SEG_BLANK : seg_of(disp_bcd_q[7:4]);
      3'd2:    seg_d = lz[2] ? SEG_BLANK : seg_of(disp_bcd_q[11:8]);
      3'd3:    seg_d = lz[3] ? SEG_BLANK : seg_of(disp_bcd_q[15:12]);
      3'd4:    seg_d = lz[4] ? SEG_BLANK : seg_of(disp_bcd_q[19:16]);
      3'd5:    seg_d = disp_sign_q ? SEG_MINUS : SEG_BLANK;
      default: seg_d = SEG_BLANK;
    endcase
  end

  // All top-level state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_pend_q <= 1'b0;
      disp_bcd_q  <= '0;
      disp_sign_q <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      an_q        <= 8'hFF;
      seg_q       <= SEG_BLANK;
    end else begin
      sign_pend_q <= sign_pend_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_sign_q <= disp_sign_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign busy      = conv_busy;
  assign done      = conv_done;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  assign dbg_state = (conv_state == CONV);

endmodule

// File: tb/tb_booth_display_scan.sv
// Bench for booth_display_scan with REFRESH_DIV=4: a behavioural display
// model checked every cycle, plus literal frame/latency expectations.
module tb_booth_display_scan;

  localparam int RDIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'd0;
  logic        signed_mode = 1'b0;
  logic        busy, done, dp, dbg_state;
  logic [7:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  booth_display_scan #(.REFRESH_DIV(RDIV), .DIV_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .value       (value),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .dbg_state   (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // What digit position pos shows for a displayed value (sign, magnitude)
  function automatic logic [6:0] model_seg(input int pos, input bit sgn, input int mag);
    int p10;
    p10 = 1;
    for (int k = 0; k < pos && k < 5; k++) p10 = p10 * 10;
    if (pos <= 4) begin
      if (pos == 0 || mag >= p10) return digit_code((mag / p10) % 10);
      return 7'b1111111;
    end
    if (pos == 5) return sgn ? 7'b0111111 : 7'b1111111;
    return 7'b1111111;
  endfunction

  logic [16:0] exp_q[$];        // accepted {sign, magnitude} awaiting commit
  int          m_e;             // edges since reset release
  bit          m_busy;
  int          commit_at;
  bit          disp_sign;
  int          disp_mag;
  int          m_idx;
  bit          m_acc;
  bit          m_sgn;
  int          m_mag;
  logic [7:0]  exp_an   = 8'hFF;
  logic [6:0]  exp_seg  = 7'h7F;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e = 0; m_busy = 0; commit_at = 0;
      exp_q.delete();
      disp_sign = 0; disp_mag = 0;
      exp_an = 8'hFF; exp_seg = 7'h7F; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      m_e++;
      m_idx   = ((m_e - 1) / RDIV) % 8;
      exp_an  = ~(8'd1 << m_idx);
      exp_seg = model_seg(m_idx, disp_sign, disp_mag);
      exp_done = 1'b0;
      m_acc = load && !m_busy;
      if (m_busy && m_e == commit_at) begin
        {disp_sign, disp_mag[15:0]} = exp_q.pop_front();
        disp_mag[31:16] = 16'd0;
        if (!disp_sign && disp_mag == 0 && signed_mode === 1'bx) disp_mag = 0;
        m_busy = 0;
        exp_done = 1'b1;
      end
      if (m_acc) begin
        m_sgn = signed_mode && value[15];
        m_mag = m_sgn ? (65536 - int'(value)) : int'(value);
        exp_q.push_back({m_sgn, m_mag[15:0]});
        m_busy = 1;
        commit_at = m_e + 16;
      end
      exp_busy = m_busy;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("busy", 32'(busy), 32'(exp_busy));
    check("done", 32'(done), 32'(exp_done));
    check("dbg_state", 32'(dbg_state), 32'(exp_busy));
    check("dp", 32'(dp), 32'd1);
  end

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge following the accepting edge
  task automatic do_load(input logic [15:0] v, input logic m);
    @(negedge clk);
    load = 1'b1; value = v; signed_mode = m;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  logic [6:0] frame_seg [8];
  task automatic capture_frame();
    for (int i = 0; i < 8; i++) frame_seg[i] = 7'h00;
    for (int c = 0; c < 8 * RDIV + 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) if (an == ~(8'd1 << k)) frame_seg[k] = seg;
    end
  endtask

  // ---------------- main sequence ----------------
  int lat;
  int d0;
  logic [7:0] an_s [36];
  logic [6:0] seg_s [36];
  logic [15:0] specials [6];

  initial begin
    specials[0] = 16'd0;     specials[1] = 16'd9;
    specials[2] = 16'd10;    specials[3] = 16'hFFFF;
    specials[4] = 16'h8000;  specials[5] = 16'd9999;

    // Reset asserted mid-cycle
    #1 rst = 1'b1;
    #2;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_busy", 32'(busy), 32'd0);
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    check("first_an", 32'(an), 32'hFE);
    check("first_seg", 32'(seg), 32'b1000000);
    capture_frame();
    check("frame0_d0", 32'(frame_seg[0]), 32'b1000000);
    for (int k = 1; k < 8; k++) check("frame0_blank", 32'(frame_seg[k]), 32'b1111111);

    // Unsigned 1234
    do_load(16'd1234, 1'b0);
    check("busy_after_load", 32'(busy), 32'd1);
    wait_done(lat);
    check("latency_1234", 32'(lat), 32'd16);
    capture_frame();
    check("u1234_d0", 32'(frame_seg[0]), 32'b0011001);
    check("u1234_d1", 32'(frame_seg[1]), 32'b0110000);
    check("u1234_d2", 32'(frame_seg[2]), 32'b0100100);
    check("u1234_d3", 32'(frame_seg[3]), 32'b1111001);
    check("u1234_d4", 32'(frame_seg[4]), 32'b1111111);
    check("u1234_d5", 32'(frame_seg[5]), 32'b1111111);

    // Signed 0xC080 = -16256
    do_load(16'hC080, 1'b1);
    wait_done(lat);
    capture_frame();
    check("sC080_d0", 32'(frame_seg[0]), 32'b0000010);
    check("sC080_d1", 32'(frame_seg[1]), 32'b0010010);
    check("sC080_d2", 32'(frame_seg[2]), 32'b0100100);
    check("sC080_d3", 32'(frame_seg[3]), 32'b0000010);
    check("sC080_d4", 32'(frame_seg[4]), 32'b1111001);
    check("sC080_d5", 32'(frame_seg[5]), 32'b0111111);

    // 0x8000 signed then unsigned: 32768
    do_load(16'h8000, 1'b1);
    wait_done(lat);
    capture_frame();
    check("s8000_d4", 32'(frame_seg[4]), 32'b0110000);
    check("s8000_d0", 32'(frame_seg[0]), 32'b0000000);
    check("s8000_d5", 32'(frame_seg[5]), 32'b0111111);
    do_load(16'h8000, 1'b0);
    wait_done(lat);
    capture_frame();
    check("u8000_d4", 32'(frame_seg[4]), 32'b0110000);
    check("u8000_d5", 32'(frame_seg[5]), 32'b1111111);

    // Load while busy: 99 then 5 at N+3
    d0 = done_cnt;
    do_load(16'd99, 1'b0);
    cycles(2);
    load = 1'b1; value = 16'd5; signed_mode = 1'b0;
    @(negedge clk);
    load = 1'b0;
    cycles(40);
    check("busy_load_done_cnt", 32'(done_cnt - d0), 32'd1);
    capture_frame();
    check("u99_d0", 32'(frame_seg[0]), 32'b0010000);
    check("u99_d1", 32'(frame_seg[1]), 32'b0010000);
    check("u99_d2", 32'(frame_seg[2]), 32'b1111111);

    // Abort mid-conversion, then check scan order and dwell
    d0 = done_cnt;
    do_load(16'd777, 1'b0);
    cycles(7);
    #2 rst = 1'b1;
    #1;
    check("abort_an", 32'(an), 32'hFF);
    check("abort_seg", 32'(seg), 32'h7F);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      an_s[i] = an; seg_s[i] = seg;
    end
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("scan_0", 32'(an_s[0]), 32'hFE);
    check("scan_3", 32'(an_s[3]), 32'hFE);
    check("scan_4", 32'(an_s[4]), 32'hFD);
    check("scan_8", 32'(an_s[8]), 32'hFB);
    check("scan_28", 32'(an_s[28]), 32'h7F);
    check("scan_31", 32'(an_s[31]), 32'h7F);
    check("scan_32", 32'(an_s[32]), 32'hFE);
    check("abort_shows0", 32'(seg_s[0]), 32'b1000000);
    check("abort_d1_blank", 32'(seg_s[4]), 32'b1111111);

    // Randomised loads, some landing while busy
    for (int it = 0; it < 30; it++) begin
      cycles($urandom_range(0, 20));
      @(negedge clk);
      load = 1'b1;
      value = (it < 6) ? specials[it] : 16'($urandom_range(0, 65535));
      signed_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      load = 1'b0;
      if (it < 6) cycles(20);
    end
    cycles(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_display_scan.md
# booth_display_scan

Output-side counterpart of the switch input register. It captures the 16-bit Booth product and converts it to five decimal digits plus a sign, using a sequential double-dabble sub-block. It then drives an 8-digit, active-low, multiplexed seven-segment display, so the board shows the result of the operands entered on the switches.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit stays lit. Must be ≥ 2.
- DIV_W, default 17: width of the refresh counter. Must satisfy 2^DIV_W ≥ REFRESH_DIV.
- clk, input, 1: system clock. The block uses one clock.
- rst, input, 1: reset, asynchronous and active-high.
- load, input, 1: capture request, sampled on the clk rising edge.
- value, input, 16: product to display.
- signed_mode, input, 1: when 1, value is two's complement; when 0, unsigned. Sampled with load.
- busy, output, 1: conversion in progress.
- done, output, 1: one-cycle pulse when the new value is committed to the display.
- an, output, 8: digit enables, active-low, exactly one low at a time.
- seg, output, 7: segments, active-low, bit order {g,f,e,d,c,b,a}.
- dp, output, 1: decimal point, active-low. Held at 1.

## Operation
- **Capture.** A load seen while busy=0 is accepted.
  - sign := signed_mode & value[15].
  - mag := sign ? (~value + 1) : value, 16-bit unsigned. 16'h8000 in signed mode gives mag 32768.
  - A load seen while busy=1 is ignored. There is no queueing.
- **Conversion (FSM, two states).**
  - IDLE: leave on an accepted load.
  - CONV: 16 shift iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts the combined 20-bit BCD and 16-bit binary register left by 1, MSB of mag first.
  - On the 16th iteration: BCD result and sign are written to the display registers, done=1 for one cycle, and the FSM returns to IDLE.
- **Double buffering.** The display keeps showing the previous value for the whole conversion.
- **Digit map** (index 0 is rightmost):
  - 0–4: BCD digits, least significant first.
  - 5: minus sign if sign=1, otherwise blank.
  - 6–7: always blank.
- **Leading-zero blanking.** Digits 4..1 are blank while they and every more-significant digit are 0. Digit 0 always shows, so a value of 0 displays "0".
- **Segment codes (gfedcba, active-low).**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - minus=0111111, blank=1111111
- **Scan.**
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0→7, then back to 0.
  - an is the one-hot low decode of the index; seg is the code for that digit.

## Timing
- **Reset values (asynchronous).**
  - Outputs: busy=0, done=0, an=8'hFF, seg=7'h7F, dp=1.
  - Internal: FSM=IDLE, display registers = 0 / sign 0, refresh counter 0, index 0.
- **After reset release.** an and seg are registered. The first edge drives an=8'hFE with seg=1000000 (the digit "0").
- **Load latency.** Load accepted at edge N:
  - busy=1 after edge N.
  - The 16th shift happens at edge N+16. That same edge sets busy=0, pulses done=1 (during cycle N+16..N+17), and updates the display registers.
  - Total capture-to-display latency is 16 cycles.
  - A new load is accepted at edge N+17 at the earliest.
- **Display update.** The first an/seg change reflecting the new value happens at the next edge after commit. The scan counter and index are never reset by load.
- **Dwell.** Each digit is lit for exactly REFRESH_DIV cycles; a full frame is 8·REFRESH_DIV cycles.
- **Reset mid-conversion.** The conversion is aborted, no done pulse is issued, and the display shows 0.

## Structure
- Package booth_disp_pkg holds:
  - the segment-code localparams (SEG_0..SEG_9, SEG_MINUS, SEG_BLANK);
  - N_DIGITS=8, N_BCD=5;
  - the FSM state enum {IDLE, CONV}.
- Sub-module bin2bcd_seq:
  - interface: start, 16-bit bin, busy, done, 20-bit bcd;
  - contains the FSM and the shift/add-3 datapath.
- The top level contains sign/magnitude capture, display registers, blanking logic, refresh counter and scan mux.

## Test plan
All scenarios use REFRESH_DIV=4.
- **Reset.** Assert rst mid-cycle, then release. Expect immediate an=FF, seg=7F, busy=0. After the first edge, an=FE, seg=1000000; digits 1–7 show blank through one frame.
- **Unsigned value.** load with value=16'd1234, signed_mode=0. Expect busy for 16 cycles, done at N+16. Digits 0..3 = 4,3,2,1; digits 4–7 blank.
- **Signed minimum product.** load with value=16'hC080 (−16256), signed_mode=1. Expect digits 6,5,2,6,1 and a minus on digit 5.
- **Signed extreme.** load with value=16'h8000, signed_mode=1. Expect 32768 with a minus. The same value with signed_mode=0 gives 32768 with digit 5 blank.
- **Load while busy.** Load 99, then load 5 at N+3. Expect only 99 displayed and exactly one done pulse.
- **Abort and refresh.** Assert rst at N+8 of a conversion. Expect no done pulse and the display shows 0. Separately, check an cycles FE, FD, …, 7F, FE with 4-cycle dwell per digit.
